// File: rtl/alu_result_monitor_pkg.sv
// Shared definitions for the dual-channel ALU result monitor.
//   status_e : classification of one dual-channel result (PASS / DEGRADED / FAIL)
//   state_e  : monitor operating state (RUN / LOCKOUT)
//   ERR_CLEAN: the only two-rail error code that marks a channel as trustworthy
package alu_result_monitor_pkg;

    typedef enum logic [1:0] {
        ST_PASS = 2'b00,
        ST_DEGR = 2'b01,
        ST_FAIL = 2'b10
    } status_e;

    typedef enum logic {
        S_RUN     = 1'b0,
        S_LOCKOUT = 1'b1
    } state_e;

    // Two-rail checker output: E1=1, E0=0 means "no error"; 00/01/11 are flagged.
    localparam logic [1:0] ERR_CLEAN = 2'b10;

    function automatic logic is_clean(input logic [1:0] err);
        return err == ERR_CLEAN;
    endfunction

endpackage

// File: rtl/alu_result_monitor_classifier.sv
// result_classifier: combinational comparison of the two redundant ALU channels.
// Ports:
//   x_sum/x_carry/x_err : channel X result and two-rail error code
//   y_sum/y_carry/y_err : channel Y result and two-rail error code
//   result              : selected {carry,sum}, zero on FAIL
//   status              : status_e encoding (PASS / DEGRADED / FAIL)
module result_classifier
    import alu_result_monitor_pkg::*;
(
    input  logic [2:0] x_sum,
    input  logic       x_carry,
    input  logic [1:0] x_err,
    input  logic [2:0] y_sum,
    input  logic       y_carry,
    input  logic [1:0] y_err,
    output logic [3:0] result,
    output logic [1:0] status
);

    logic       x_ok;
    logic       y_ok;
    logic [3:0] x_val;
    logic [3:0] y_val;

    assign x_ok  = is_clean(x_err);
    assign y_ok  = is_clean(y_err);
    assign x_val = {x_carry, x_sum};
    assign y_val = {y_carry, y_sum};

    always_comb begin
        result = 4'b0000;
        status = ST_FAIL;
        if (x_ok && y_ok) begin
            // Both channels claim to be good: they must agree, otherwise
            // there is no way to tell which one is lying.
            if (x_val == y_val) begin
                result = x_val;
                status = ST_PASS;
            end
        end else if (x_ok) begin
            result = x_val;
            status = ST_DEGR;
        end else if (y_ok) begin
            result = y_val;
            status = ST_DEGR;
        end
    end

endmodule

// File: rtl/alu_result_monitor.sv
// alu_result_monitor: classifies dual-channel ALU results, registers them behind
// a single-entry valid/ready output stage, counts FAIL/DEGRADED events and
// locks out further input after LOCK_THRESH consecutive FAIL results.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   in_valid/in_ready        : input handshake for one dual-channel result
//   x_*/y_*                  : channel X / Y sum, carry and two-rail error
//   out_valid/out_ready      : output handshake
//   out_result, out_status   : registered {carry,sum} and classification
//   fail_cnt, degr_cnt       : saturating event counters
//   locked, clear_lock       : lockout indication and release
module alu_result_monitor
    import alu_result_monitor_pkg::*;
#(
    parameter int LOCK_THRESH = 3,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       x_sum,
    input  logic             x_carry,
    input  logic [1:0]       x_err,
    input  logic [2:0]       y_sum,
    input  logic             y_carry,
    input  logic [1:0]       y_err,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_result,
    output logic [1:0]       out_status,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] degr_cnt,
    output logic             locked,
    input  logic             clear_lock
);

    // Consecutive-fail counter only ever needs to reach LOCK_THRESH.
    localparam int            CW        = $clog2(LOCK_THRESH + 1);
    localparam logic [CW-1:0] THRESH_M1 = CW'(LOCK_THRESH - 1);

    state_e           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [3:0]       out_result_q, out_result_d;
    logic [1:0]       out_status_q, out_status_d;
    logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
    logic [CNT_W-1:0] degr_cnt_q, degr_cnt_d;
    logic [CW-1:0]    consec_q, consec_d;

    logic [3:0]       cls_result;
    logic [1:0]       cls_status;
    logic             xfer;

    result_classifier u_classifier (
        .x_sum   (x_sum),
        .x_carry (x_carry),
        .x_err   (x_err),
        .y_sum   (y_sum),
        .y_carry (y_carry),
        .y_err   (y_err),
        .result  (cls_result),
        .status  (cls_status)
    );

    // Ready whenever the output slot is free or being drained this cycle.
    assign in_ready = !rst && (state_q == S_RUN) && (!out_valid_q || out_ready);
    assign xfer     = in_valid && in_ready;

    always_comb begin
        state_d      = state_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_status_d = out_status_q;
        fail_cnt_d   = fail_cnt_q;
        degr_cnt_d   = degr_cnt_q;
        consec_d     = consec_q;

        if (xfer) begin
            // Load replaces any result being accepted in the same cycle.
            out_valid_d  = 1'b1;
            out_result_d = cls_result;
            out_status_d = cls_status;
            if (cls_status == ST_FAIL) begin
                if (fail_cnt_q != {CNT_W{1'b1}}) fail_cnt_d = fail_cnt_q + CNT_W'(1);
                consec_d = consec_q + CW'(1);
                if (consec_q == THRESH_M1) state_d = S_LOCKOUT;
            end else begin
                consec_d = '0;
                if (cls_status == ST_DEGR && degr_cnt_q != {CNT_W{1'b1}})
                    degr_cnt_d = degr_cnt_q + CNT_W'(1);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        // No transfer can happen in LOCKOUT, so this never collides with the above.
        if (state_q == S_LOCKOUT && clear_lock) begin
            state_d  = S_RUN;
            consec_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_RUN;
            out_valid_q  <= 1'b0;
            out_result_q <= 4'b0000;
            out_status_q <= ST_PASS;
            fail_cnt_q   <= '0;
            degr_cnt_q   <= '0;
            consec_q     <= '0;
        end else begin
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_status_q <= out_status_d;
            fail_cnt_q   <= fail_cnt_d;
            degr_cnt_q   <= degr_cnt_d;
            consec_q     <= consec_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_status = out_status_q;
    assign fail_cnt   = fail_cnt_q;
    assign degr_cnt   = degr_cnt_q;
    assign locked     = (state_q == S_LOCKOUT);

endmodule
